// File: rtl/button_event_controller.sv
// Classifies debounced button levels into PRESS/LONG/REPEAT/RELEASE events behind one round-robin valid/ready port.
// Input change to o_evt_valid takes 2 cycles; under backpressure each button holds one pending event, newer overwrites and sets its drop flag.
module button_event_controller #(
   parameter int NUM_BUTTONS   = 4,
   parameter int LONG_PRESS    = 500,
   parameter int REPEAT_PERIOD = 100,
   parameter int CNT_W         = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_tick,
   input  logic [NUM_BUTTONS-1:0] i_btn_level,
   output logic                   o_evt_valid,
   input  logic                   i_evt_ready,
   output logic [2:0]             o_evt_id,
   output logic [1:0]             o_evt_type,
   output logic [NUM_BUTTONS-1:0] o_drop_flags,
   input  logic                   i_drop_clr
);

   typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_t;

   localparam logic [1:0] EV_PRESS   = 2'd0;
   localparam logic [1:0] EV_LONG    = 2'd1;
   localparam logic [1:0] EV_REPEAT  = 2'd2;
   localparam logic [1:0] EV_RELEASE = 2'd3;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
   localparam bit               REP_EN    = (REPEAT_PERIOD != 0);

   state_t                   r_state     [NUM_BUTTONS];
   logic [CNT_W-1:0]         r_cnt       [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0]   r_slot_vld;
   logic [1:0]               r_slot_type [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0]   r_drop;
   logic [2:0]               r_last_grant;
   logic                     r_evt_valid;
   logic [2:0]               r_evt_id;
   logic [1:0]               r_evt_type;

   logic [NUM_BUTTONS-1:0]   w_post;
   logic [1:0]               w_post_type [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0]   w_grant;
   logic [NUM_BUTTONS-1:0]   w_drop;
   logic                     w_load;
   logic                     w_found;
   logic [2:0]               w_win_id;
   logic [1:0]               w_win_type;

   assign o_evt_valid  = r_evt_valid;
   assign o_evt_id     = r_evt_id;
   assign o_evt_type   = r_evt_type;
   assign o_drop_flags = r_drop;
   assign w_load       = !r_evt_valid || i_evt_ready;

   // Events are posted in the same cycle the FSM sees the qualifying input.
   always_comb begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         w_post[i]      = 1'b0;
         w_post_type[i] = EV_PRESS;
         case (r_state[i])
            S_IDLE: begin
               if (i_btn_level[i]) begin
                  w_post[i]      = 1'b1;
                  w_post_type[i] = EV_PRESS;
               end
            end
            S_PRESSED: begin
               if (!i_btn_level[i]) begin
                  w_post[i]      = 1'b1;
                  w_post_type[i] = EV_RELEASE;
               end else if (i_tick && r_cnt[i] == LONG_LAST) begin
                  w_post[i]      = 1'b1;
                  w_post_type[i] = EV_LONG;
               end
            end
            S_HELD: begin
               if (!i_btn_level[i]) begin
                  w_post[i]      = 1'b1;
                  w_post_type[i] = EV_RELEASE;
               end else if (i_tick && REP_EN && r_cnt[i] == REP_LAST) begin
                  w_post[i]      = 1'b1;
                  w_post_type[i] = EV_REPEAT;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            r_state[i] <= S_IDLE;
            r_cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            case (r_state[i])
               S_IDLE: begin
                  if (i_btn_level[i]) begin
                     r_cnt[i]   <= '0;
                     r_state[i] <= S_PRESSED;
                  end
               end
               S_PRESSED: begin
                  if (!i_btn_level[i]) begin
                     r_state[i] <= S_IDLE;
                  end else if (i_tick) begin
                     if (r_cnt[i] == LONG_LAST) begin
                        r_cnt[i]   <= '0;
                        r_state[i] <= S_HELD;
                     end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                     end
                  end
               end
               S_HELD: begin
                  if (!i_btn_level[i]) begin
                     r_state[i] <= S_IDLE;
                  end else if (i_tick && REP_EN) begin
                     if (r_cnt[i] == REP_LAST) r_cnt[i] <= '0;
                     else                      r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                  end
               end
               default: r_state[i] <= S_IDLE;
            endcase
         end
      end
   end

   // Round-robin search starting one past the last granted button.
   always_comb begin
      w_found    = 1'b0;
      w_win_id   = 3'd0;
      w_win_type = EV_PRESS;
      for (int k = 1; k <= NUM_BUTTONS; k++) begin
         int t;
         t = int'(r_last_grant) + k;
         if (t >= NUM_BUTTONS) t = t - NUM_BUTTONS;
         for (int j = 0; j < NUM_BUTTONS; j++) begin
            if (!w_found && t == j && r_slot_vld[j]) begin
               w_found    = 1'b1;
               w_win_id   = 3'(j);
               w_win_type = r_slot_type[j];
            end
         end
      end
      for (int j = 0; j < NUM_BUTTONS; j++) begin
         w_grant[j] = w_load && w_found && (w_win_id == 3'(j));
         w_drop[j]  = w_post[j] && r_slot_vld[j] && !w_grant[j];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_slot_vld   <= '0;
         r_drop       <= '0;
         r_last_grant <= 3'(NUM_BUTTONS - 1);
         r_evt_valid  <= 1'b0;
         r_evt_id     <= 3'd0;
         r_evt_type   <= 2'd0;
         for (int i = 0; i < NUM_BUTTONS; i++) r_slot_type[i] <= 2'd0;
      end else begin
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            // A post into a slot being granted this cycle refills it without loss.
            if (w_post[i]) begin
               r_slot_vld[i]  <= 1'b1;
               r_slot_type[i] <= w_post_type[i];
            end else if (w_grant[i]) begin
               r_slot_vld[i]  <= 1'b0;
            end
            r_drop[i] <= w_drop[i] || (r_drop[i] && !i_drop_clr);
         end
         if (w_load) begin
            if (w_found) begin
               r_evt_valid  <= 1'b1;
               r_evt_id     <= w_win_id;
               r_evt_type   <= w_win_type;
               r_last_grant <= w_win_id;
            end else begin
               r_evt_valid  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_button_event_controller.sv
// Bench for button_event_controller: directed scenarios then random traffic, two instances (repeat on / repeat off).
module tb_button_event_controller;

   localparam int N  = 4;
   localparam int LP = 5;
   localparam int RP = 3;

   logic         clk = 1'b0;
   logic         rst, tick, rdy, clr;
   logic [N-1:0] lvl;

   logic         a_v,  b_v;
   logic [2:0]   a_id, b_id;
   logic [1:0]   a_ty, b_ty;
   logic [N-1:0] a_df, b_df;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   button_event_controller #(.NUM_BUTTONS(N), .LONG_PRESS(LP), .REPEAT_PERIOD(RP), .CNT_W(16)) dut_a (
      .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_btn_level(lvl),
      .o_evt_valid(a_v), .i_evt_ready(rdy), .o_evt_id(a_id), .o_evt_type(a_ty),
      .o_drop_flags(a_df), .i_drop_clr(clr));

   button_event_controller #(.NUM_BUTTONS(N), .LONG_PRESS(LP), .REPEAT_PERIOD(0), .CNT_W(16)) dut_b (
      .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_btn_level(lvl),
      .o_evt_valid(b_v), .i_evt_ready(rdy), .o_evt_id(b_id), .o_evt_type(b_ty),
      .o_drop_flags(b_df), .i_drop_clr(clr));

   // Reference model: per button "pressed" flag plus ticks held since press.
   bit           m_pr   [2][N];
   int           m_ht   [2][N];
   bit           m_sv   [2][N];
   logic [1:0]   m_st   [2][N];
   logic [N-1:0] m_drop [2];
   bit           m_ov   [2];
   logic [2:0]   m_oid  [2];
   logic [1:0]   m_ot   [2];
   int           m_last [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic model_step(input int u, input int rp);
      bit         post [N];
      logic [1:0] pt   [N];
      bit         load, found, gr;
      int         w;
      logic [1:0] wt;
      if (rst) begin
         for (int b = 0; b < N; b++) begin
            m_pr[u][b] = 0; m_ht[u][b] = 0; m_sv[u][b] = 0; m_st[u][b] = 2'd0;
         end
         m_drop[u] = '0; m_ov[u] = 0; m_oid[u] = 3'd0; m_ot[u] = 2'd0; m_last[u] = N - 1;
         return;
      end
      load  = !m_ov[u] || rdy;
      found = 0; w = 0; wt = 2'd0;
      for (int k = 1; k <= N; k++) begin
         int b;
         b = (m_last[u] + k) % N;
         if (!found && m_sv[u][b]) begin found = 1; w = b; wt = m_st[u][b]; end
      end
      for (int b = 0; b < N; b++) begin
         post[b] = 0; pt[b] = 2'd0;
         if (!m_pr[u][b]) begin
            if (lvl[b]) begin post[b] = 1; pt[b] = 2'd0; m_pr[u][b] = 1; m_ht[u][b] = 0; end
         end else if (!lvl[b]) begin
            post[b] = 1; pt[b] = 2'd3; m_pr[u][b] = 0;
         end else if (tick) begin
            m_ht[u][b]++;
            if (m_ht[u][b] == LP) begin post[b] = 1; pt[b] = 2'd1; end
            else if (rp != 0 && m_ht[u][b] > LP && (m_ht[u][b] - LP) % rp == 0) begin
               post[b] = 1; pt[b] = 2'd2;
            end
         end
      end
      for (int b = 0; b < N; b++) begin
         gr = load && found && (w == b);
         if (post[b] && m_sv[u][b] && !gr) m_drop[u][b] = 1'b1;
         else if (clr)                     m_drop[u][b] = 1'b0;
         if (post[b])  begin m_sv[u][b] = 1; m_st[u][b] = pt[b]; end
         else if (gr)  m_sv[u][b] = 0;
      end
      if (load) begin
         if (found) begin m_ov[u] = 1; m_oid[u] = 3'(w); m_ot[u] = wt; m_last[u] = w; end
         else m_ov[u] = 0;
      end
   endtask

   task automatic compare_unit(input int u, input logic v, input logic [2:0] id,
                               input logic [1:0] ty, input logic [N-1:0] df);
      string p;
      p = (u == 0) ? "a_" : "b_";
      chk({p, "valid"}, 32'(v), 32'(m_ov[u]));
      if (m_ov[u]) begin
         chk({p, "id"},   32'(id), 32'(m_oid[u]));
         chk({p, "type"}, 32'(ty), 32'(m_ot[u]));
      end
      chk({p, "drop"}, 32'(df), 32'(m_drop[u]));
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      model_step(0, RP);
      model_step(1, 0);
      compare_unit(0, a_v, a_id, a_ty, a_df);
      compare_unit(1, b_v, b_id, b_ty, b_df);
   endtask

   int na_long, na_rep, nb_long, nb_rep;

   task automatic cycle_count();
      cycle();
      if (a_v && a_ty == 2'd1) na_long++;
      if (a_v && a_ty == 2'd2) na_rep++;
      if (b_v && b_ty == 2'd1) nb_long++;
      if (b_v && b_ty == 2'd2) nb_rep++;
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; rdy = 1'b1; clr = 1'b0; lvl = '0;
      for (int u = 0; u < 2; u++) m_last[u] = N - 1;
      repeat (3) cycle();
      chk("rst_valid", 32'(a_v), 0);
      chk("rst_id",    32'(a_id), 0);
      chk("rst_type",  32'(a_ty), 0);
      chk("rst_drop",  32'(a_df), 0);
      rst = 1'b0;
      cycle();

      // single press / release on button 2
      lvl[2] = 1'b1; cycle();
      chk("press_lat1", 32'(a_v), 0);
      cycle();
      chk("press_v",  32'(a_v), 1);
      chk("press_id", 32'(a_id), 2);
      chk("press_ty", 32'(a_ty), 0);
      repeat (3) begin tick = 1'b1; cycle(); tick = 1'b0; cycle(); cycle(); end
      lvl[2] = 1'b0; cycle();
      chk("rel_lat1", 32'(a_v), 0);
      cycle();
      chk("rel_v",  32'(a_v), 1);
      chk("rel_id", 32'(a_id), 2);
      chk("rel_ty", 32'(a_ty), 3);
      cycle();

      // long hold on button 1 for 12 ticks
      na_long = 0; na_rep = 0; nb_long = 0; nb_rep = 0;
      lvl[1] = 1'b1; cycle_count(); cycle_count();
      for (int t = 1; t <= 12; t++) begin
         tick = 1'b1; cycle_count(); tick = 1'b0; cycle_count(); cycle_count();
      end
      lvl[1] = 1'b0; cycle_count(); cycle_count(); cycle_count();
      chk("long_cnt",   32'(na_long), 1);
      chk("rep_cnt",    32'(na_rep),  2);
      chk("long_cnt_0", 32'(nb_long), 1);
      chk("rep_cnt_0",  32'(nb_rep),  0);

      // fairness from reset, then from last_grant=1
      rst = 1'b1; cycle(); rst = 1'b0; cycle();
      lvl = 4'hF; cycle();
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("rr0_v",  32'(a_v), 1);
         chk("rr0_id", 32'(a_id), 32'(k));
      end
      lvl = 4'h0; repeat (6) cycle();
      lvl[1] = 1'b1; cycle(); cycle(); lvl[1] = 1'b0; cycle(); cycle(); cycle();
      lvl = 4'hF; cycle();
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("rr1_id", 32'(a_id), 32'((k + 2) % 4));
      end
      lvl = 4'h0; repeat (6) cycle();

      // backpressure, overwrite and drop_clr on button 0
      rdy = 1'b0;
      lvl[0] = 1'b1; cycle(); cycle();
      chk("bp_v",  32'(a_v), 1);
      chk("bp_id", 32'(a_id), 0);
      lvl[0] = 1'b0; cycle();
      chk("bp_hold_ty", 32'(a_ty), 0);
      chk("bp_nodrop",  32'(a_df), 0);
      lvl[0] = 1'b1; cycle();
      chk("bp_drop",    32'(a_df), 1);
      chk("bp_hold_id", 32'(a_id), 0);
      clr = 1'b1; cycle(); clr = 1'b0;
      chk("bp_clr", 32'(a_df), 0);
      rdy = 1'b1; lvl[0] = 1'b0; repeat (6) cycle();

      // grant and post on button 3 in the same cycle
      lvl[3] = 1'b1; cycle();
      lvl[3] = 1'b0; cycle();
      chk("gp_press_id", 32'(a_id), 3);
      chk("gp_press_ty", 32'(a_ty), 0);
      cycle();
      chk("gp_rel_v",  32'(a_v), 1);
      chk("gp_rel_ty", 32'(a_ty), 3);
      chk("gp_drop3",  32'(a_df[3]), 0);
      repeat (2) cycle();

      // reset while button 0 is held with events pending
      rdy = 1'b0; lvl[0] = 1'b1; cycle();
      repeat (LP + 1) begin tick = 1'b1; cycle(); tick = 1'b0; cycle(); end
      rst = 1'b1; cycle();
      chk("mr_v",    32'(a_v), 0);
      chk("mr_id",   32'(a_id), 0);
      chk("mr_drop", 32'(a_df), 0);
      rst = 1'b0; cycle();
      chk("mr_lat1", 32'(a_v), 0);
      cycle();
      chk("mr_press_v",  32'(a_v), 1);
      chk("mr_press_id", 32'(a_id), 0);
      chk("mr_press_ty", 32'(a_ty), 0);
      rdy = 1'b1; lvl = '0; repeat (4) cycle();

      // random traffic
      repeat (5000) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 39) == 0) lvl[b] = ~lvl[b];
         tick = ($urandom_range(0, 2) == 0);
         rdy  = ($urandom_range(0, 1) == 0);
         clr  = ($urandom_range(0, 19) == 0);
         rst  = ($urandom_range(0, 799) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/button_event_controller.md
# button_event_controller

Sequences the debounced button levels from a bank of NUM_BUTTONS debouncers into a single stream of classified events (press, long-press, auto-repeat, release). Each button has its own timing state machine driven by a slow tick; a round-robin arbiter shares one valid/ready event port among all buttons. It sits between the debouncer bank and the UI/menu logic.

## Interface
- NUM_BUTTONS, 4: number of debounced button inputs, range 2..8
- LONG_PRESS, 500: ticks held before a LONG event, at least 2
- REPEAT_PERIOD, 100: ticks between REPEAT events while held; 0 disables repeat
- CNT_W, 16: per-button tick counter width; must hold max(LONG_PRESS, REPEAT_PERIOD)
- clk  in  1  single system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle timing strobe (e.g. 1 kHz enable)
- btn_level  in  NUM_BUTTONS  debounced levels, 1 = pressed
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts the event when high with evt_valid
- evt_id  out  3  index of the button that produced the event
- evt_type  out  2  00 PRESS, 01 LONG, 10 REPEAT, 11 RELEASE
- drop_flags  out  NUM_BUTTONS  sticky per-button lost-event flags
- drop_clr  in  1  clears all drop_flags

## Operation
- Per-button FSM, states IDLE, PRESSED, HELD; counter cnt (CNT_W bits):
  - IDLE: btn_level=1 -> post PRESS, cnt=0, go PRESSED.
  - PRESSED: btn_level=0 -> post RELEASE, go IDLE (takes precedence over tick). Else on tick: if cnt==LONG_PRESS-1, post LONG, cnt=0, go HELD; otherwise cnt+1.
  - HELD: btn_level=0 -> post RELEASE, go IDLE. Else on tick with REPEAT_PERIOD!=0: if cnt==REPEAT_PERIOD-1, post REPEAT, cnt=0; otherwise cnt+1. With REPEAT_PERIOD=0, cnt is held.
  - Ticks do not advance cnt in IDLE.
- Each button has a one-entry pending slot (valid bit + 2-bit type). A post writes the slot. If the slot is already valid and not being granted this cycle, the new event overwrites it and drop_flags[i] is set.
- Output register: loads when evt_valid=0 or (evt_valid & evt_ready). The winner is the first button with a valid slot, searching round-robin from last_grant+1 (wrapping); its slot is cleared and last_grant is updated. With no pending slot, evt_valid goes 0 on acceptance.
- Grant and post to the same slot in one cycle: the old entry goes out and the new entry occupies the slot. No drop.
- evt_id, evt_type are stable while evt_valid=1 and evt_ready=0.
- drop_clr clears drop_flags. A drop in the same cycle wins, so the flag stays 1.

## Timing
- Reset (synchronous): evt_valid=0, evt_id=0, evt_type=0, drop_flags=0, all FSMs IDLE, cnt=0, slots empty, last_grant=NUM_BUTTONS-1 (first search starts at button 0).
- A button high during reset posts PRESS on the first cycle after reset deasserts.
- Latency: btn_level change seen at edge k writes the slot at edge k. With the output register free, evt_valid=1 after edge k+1 (2 cycles from input to event).
- LONG is posted at the edge of the LONG_PRESS-th tick after the PRESS post.
- REPEAT is posted every REPEAT_PERIOD ticks after LONG.
- Throughput: one event per cycle when evt_ready is held high.
- Reset mid-operation discards all pending and output events. No RELEASE is emitted for buttons that were held.

## Test plan
- Single press/release, N=4, LONG_PRESS=5: raise btn_level[2] for 3 ticks, then drop it, ready=1. Required: PRESS id2, then RELEASE id2, no LONG; evt_valid high 2 cycles after each edge.
- Long hold, LONG_PRESS=5, REPEAT_PERIOD=3: hold btn 1 for 12 ticks. Required: PRESS, LONG at tick 5, REPEAT at ticks 8 and 11, then RELEASE. REPEAT_PERIOD=0 gives no REPEAT.
- Arbitration fairness: raise buttons 0–3 in the same cycle, ready=1. Required: PRESS ids 0,1,2,3 on consecutive cycles. Repeat with last_grant=1: order is 2,3,0,1.
- Backpressure: ready=0, press and release btn 0. Required: output holds PRESS id0 stable. The RELEASE waits in the slot. A second press overwrites it and sets drop_flags[0]=1. drop_clr then clears the flag.
- Simultaneous grant and post: with btn 3's slot being granted, post RELEASE in the same cycle. Required: RELEASE delivered next, drop_flags[3]=0.
- Reset mid-hold: assert reset while btn 0 is in HELD with a pending event. Required: all outputs 0. With btn 0 still high after reset, PRESS id0 appears 2 cycles later.
